sb_arbiter: RTL and testbench

Two-master round-robin arbiter for the single-cycle peripheral system bus (LED, switch and similar `*_sb_ctrl` slaves). It sits between the core's load/store port (master 0) and a second bus master such as a debug or DMA unit (master 1), and drives one shared request to the peripheral decoder. It routes the one-cycle-late read data back to the master that issued the read. It also supports locked sequences, so a master can hold the bus for an atomic read-modify-write of a peripheral register.

---
 rtl/sb_arbiter.sv | 148 ++++++++++++++
 tb/tb_sb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sb_arbiter.sv
// Two-master round-robin arbiter for the single-cycle peripheral bus.
// Supports locked sequences and routes one-cycle-late read data back.
module sb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic              sb_req_o,
  output logic              sb_we_o,
  output logic [ADDR_W-1:0] sb_addr_o,
  output logic [DATA_W-1:0] sb_wdata_o,
  input  logic [DATA_W-1:0] sb_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } lock_e;

  lock_e lock_state_q;
  lock_e lock_state_d;
  logic  prio_q;
  logic  prio_d;
  logic  rsp_valid_q;
  logic  rsp_valid_d;
  logic  rsp_owner_q;
  logic  rsp_owner_d;

  logic  elig0;
  logic  elig1;
  logic  r0;
  logic  r1;
  logic  gnt0;
  logic  gnt1;
  logic  any_gnt;

  // A held lock masks the other master out entirely.
  always_comb begin
    elig0 = (lock_state_q != S_LOCK1);
    elig1 = (lock_state_q != S_LOCK0);
    r0 = m0_req_i & elig0;
    r1 = m1_req_i & elig1;
    gnt0 = r0 & (~r1 | ~prio_q);
    gnt1 = r1 & (~r0 | prio_q);
    any_gnt = gnt0 | gnt1;
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    sb_req_o   = 1'b0;
    sb_we_o    = 1'b0;
    sb_addr_o  = '0;
    sb_wdata_o = '0;
    unique case (1'b1)
      gnt0: begin
        sb_req_o   = 1'b1;
        sb_we_o    = m0_we_i;
        sb_addr_o  = m0_addr_i;
        sb_wdata_o = m0_wdata_i;
      end
      gnt1: begin
        sb_req_o   = 1'b1;
        sb_we_o    = m1_we_i;
        sb_addr_o  = m1_addr_i;
        sb_wdata_o = m1_wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    lock_state_d = lock_state_q;
    prio_d       = prio_q;
    unique case (lock_state_q)
      S_IDLE: begin
        if (gnt0 && m0_lock_i) begin
          lock_state_d = S_LOCK0;
        end else if (gnt1 && m1_lock_i) begin
          lock_state_d = S_LOCK1;
        end
        if (any_gnt) begin
          prio_d = gnt0;
        end
      end
      S_LOCK0: begin
        if (!m0_lock_i) begin
          lock_state_d = S_IDLE;
        end
      end
      S_LOCK1: begin
        if (!m1_lock_i) begin
          lock_state_d = S_IDLE;
        end
      end
      default: lock_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = any_gnt & ~sb_we_o;
    rsp_owner_d = any_gnt ? gnt1 : rsp_owner_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_state_q <= S_IDLE;
      prio_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      prio_q       <= prio_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  always_comb begin
    m0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
    m1_rvalid_o = rsp_valid_q & rsp_owner_q;
    m0_rdata_o  = m0_rvalid_o ? sb_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? sb_rdata_i : '0;
  end

endmodule

// File: tb/tb_sb_arbiter.sv
// Scoreboard bench for sb_arbiter: directed cycles push expected grants
// and read responses; a negedge monitor pops and compares them.
module tb_sb_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        sb_req, sb_we;
  logic [31:0] sb_addr, sb_wdata, sb_rdata;

  int n_chk;
  int n_fail;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          m;
    logic [31:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  sb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .sb_req_o(sb_req), .sb_we_o(sb_we), .sb_addr_o(sb_addr),
    .sb_wdata_o(sb_wdata), .sb_rdata_i(sb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    case (a)
      32'h0:    return 32'h0000_0011;
      32'h4:    return 32'h0000_0022;
      32'h24:   return 32'h0000_ABCD;
      default:  return 32'h0;
    endcase
  endfunction

  // Single-cycle slave: read data valid the cycle after the request.
  always @(posedge clk) begin
    if (sb_req && !sb_we) sb_rdata <= slave_rd(sb_addr);
    else                  sb_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every grant and every response must match a queued entry.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (rst) begin
      chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
      chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);
    end else begin
      if (m0_gnt && m1_gnt) chk("dual_gnt", 32'h1, 32'h0);
      if (m0_gnt || m1_gnt) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
        end else begin
          g = gq.pop_front();
          chk("gnt_master", m1_gnt ? 32'd1 : 32'd0, g.m);
          chk("sb_req", {31'b0, sb_req}, 32'h1);
          chk("sb_we", {31'b0, sb_we}, {31'b0, g.we});
          chk("sb_addr", sb_addr, g.addr);
          chk("sb_wdata", sb_wdata, g.wdata);
        end
      end else begin
        chk("idle_sb_req", {31'b0, sb_req}, 32'h0);
      end
      if (m0_rvalid && m1_rvalid) chk("dual_rvalid", 32'h1, 32'h0);
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        end else begin
          r = rq.pop_front();
          chk("rsp_master", m1_rvalid ? 32'd1 : 32'd0, r.m);
          chk("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, r.d);
        end
      end
      if (!m0_rvalid) chk("m0_rdata_zero", m0_rdata, 32'h0);
      if (!m1_rvalid) chk("m1_rdata_zero", m1_rdata, 32'h0);
    end
  end

  task automatic drive(input logic r0, w0, l0, input logic [31:0] a0, d0,
                       input logic r1, w1, l1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  // eg: expected granted master (-1 none); erd: expected read data.
  task automatic expect_gnt(input int eg, input logic [31:0] erd);
    gexp_t g;
    rexp_t r;
    if (eg == 0) begin
      g = '{0, m0_we, m0_addr, m0_wdata};
      gq.push_back(g);
      if (!m0_we) begin r = '{0, erd}; rq.push_back(r); end
    end else if (eg == 1) begin
      g = '{1, m1_we, m1_addr, m1_wdata};
      gq.push_back(g);
      if (!m1_we) begin r = '{1, erd}; rq.push_back(r); end
    end
  endtask

  task automatic cyc(input logic r0, w0, l0, input logic [31:0] a0, d0,
                     input logic r1, w1, l1, input logic [31:0] a1, d1,
                     input int eg, input logic [31:0] erd);
    drive(r0, w0, l0, a0, d0, r1, w1, l1, a1, d1);
    expect_gnt(eg, erd);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0,0,0,0,0, 0,0,0,0,0, -1, 0);
  endtask

  task automatic do_reset();
    drive(0,0,0,0,0, 0,0,0,0,0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    drive(0,0,0,0,0, 0,0,0,0,0);
    #2;
    chk("reset_sb_req", {31'b0, sb_req}, 32'h0);
    chk("reset_sb_addr", sb_addr, 32'h0);
    chk("reset_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Lone m0 read of 0x24.
    cyc(1,0,0,32'h24,0, 0,0,0,0,0, 0, 32'h0000_ABCD);
    idle();
    idle();

    // Both write continuously from reset: m0, m1, m0, m1.
    do_reset();
    cyc(1,1,0,32'h10,32'hA0, 1,1,0,32'h20,32'hB0, 0, 0);
    cyc(1,1,0,32'h14,32'hA1, 1,1,0,32'h20,32'hB0, 1, 0);
    cyc(1,1,0,32'h14,32'hA1, 1,1,0,32'h24,32'hB1, 0, 0);
    cyc(0,0,0,32'h0,32'h0,   1,1,0,32'h24,32'hB1, 1, 0);
    idle();

    // Alternating back-to-back reads: m1 then m0.
    cyc(0,0,0,0,0, 1,0,0,32'h0,0, 1, 32'h11);
    cyc(1,0,0,32'h4,0, 0,0,0,0,0, 0, 32'h22);
    idle();
    idle();

    // m0 locked RMW while m1 keeps requesting a write.
    do_reset();
    cyc(1,0,1,32'h24,0,     1,1,0,32'h30,32'hC0, 0, 32'h0000_ABCD);
    cyc(1,1,1,32'h24,32'h5, 1,1,0,32'h30,32'hC0, 0, 0);
    cyc(1,1,0,32'h28,32'h6, 1,1,0,32'h30,32'hC0, 0, 0);
    cyc(0,0,0,0,0,          1,1,0,32'h30,32'hC0, 1, 0);

    // Quiet after an m1 grant: priority stays with m0.
    repeat (3) begin
      idle();
      chk("quiet_sb_req", {31'b0, sb_req}, 32'h0);
    end
    cyc(1,0,0,32'h4,0, 1,0,0,32'h0,0, 0, 32'h22);
    cyc(0,0,0,0,0,     1,0,0,32'h0,0, 1, 32'h11);
    idle();
    idle();

    // Reset mid-cycle while LOCK1 with a read being granted.
    cyc(0,0,0,0,0, 1,1,1,32'h40,32'hD0, 1, 0);
    drive(1,1,0,32'h44,32'hE0, 1,0,1,32'h24,0);
    begin
      gexp_t g;
      g = '{1, 1'b0, 32'h24, 32'h0};
      gq.push_back(g);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    drive(0,0,0,0,0, 0,0,0,0,0);
    @(posedge clk); #1;
    chk("midrst_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("postrst_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
    cyc(1,1,0,32'h44,32'hE0, 1,1,0,32'h48,32'hF0, 0, 0);
    cyc(0,0,0,0,0,           1,1,0,32'h48,32'hF0, 1, 0);
    idle();
    idle();

    chk("gnt_queue_empty", gq.size(), 32'd0);
    chk("rsp_queue_empty", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
